// File: rtl/otter_cu_fsm_if.sv
// Control/status bundle between the OTTER datapath and its multi-cycle sequencer.
interface otter_cu_fsm_if;
    logic       INTR;
    logic       MIE;
    logic [6:0] opcode;
    logic [2:0] func3;
    logic       mem_ack;

    logic       pc_rst;
    logic       PCWrite;
    logic       regWrite;
    logic       memRDEN1;
    logic       memRDEN2;
    logic       memWE2;
    logic       csr_WE;
    logic       int_taken;
    logic       mret_exec;
    logic [2:0] imm_sel;
    logic       mem_fault;
    logic       illegal;
    logic [2:0] state;

    // Sequencer side: consumes decode/status, drives the enables.
    modport master (
        input  INTR, MIE, opcode, func3, mem_ack,
        output pc_rst, PCWrite, regWrite, memRDEN1, memRDEN2, memWE2,
               csr_WE, int_taken, mret_exec, imm_sel, mem_fault, illegal, state
    );

    // Datapath side: supplies decode/status, receives the enables.
    modport slave (
        output INTR, MIE, opcode, func3, mem_ack,
        input  pc_rst, PCWrite, regWrite, memRDEN1, memRDEN2, memWE2,
               csr_WE, int_taken, mret_exec, imm_sel, mem_fault, illegal, state
    );
endinterface

// File: rtl/otter_cu_fsm.sv
// OTTER RV32I multi-cycle control sequencer: fetch, execute, bounded data-memory
// wait, writeback and interrupt entry. Outputs decode combinationally from state
// so that reset drops every enable immediately.
module otter_cu_fsm #(
    parameter int unsigned MEM_TIMEOUT = 16
) (
    input  logic              CLK,
    input  logic              RST,
    otter_cu_fsm_if.master    bus
);
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;

    localparam logic [2:0] F3_MRET   = 3'b000;
    localparam logic [2:0] F3_CSRRW  = 3'b001;

    // Last MEM cycle index before the access is abandoned.
    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_MEM   = 3'd3,
        ST_WB    = 3'd4,
        ST_INTR  = 3'd5
    } state_t;

    state_t     cur;
    state_t     nxt;
    logic [7:0] wait_cnt;
    logic       store_flg;
    logic       done;
    logic [2:0] imm_dec;

    // Immediate format implied by the opcode.
    always_comb begin
        imm_dec = 3'd0;
        case (bus.opcode)
            OP_STORE:         imm_dec = 3'd1;
            OP_BRANCH:        imm_dec = 3'd2;
            OP_LUI, OP_AUIPC: imm_dec = 3'd3;
            OP_JAL:           imm_dec = 3'd4;
            default:          imm_dec = 3'd0;
        endcase
    end

    // Next-state and control-enable decode; 'done' marks an instruction-completion cycle.
    always_comb begin
        nxt           = cur;
        done          = 1'b0;
        bus.pc_rst    = 1'b0;
        bus.PCWrite   = 1'b0;
        bus.regWrite  = 1'b0;
        bus.memRDEN1  = 1'b0;
        bus.memRDEN2  = 1'b0;
        bus.memWE2    = 1'b0;
        bus.csr_WE    = 1'b0;
        bus.int_taken = 1'b0;
        bus.mret_exec = 1'b0;
        bus.imm_sel   = 3'd0;
        bus.mem_fault = 1'b0;
        bus.illegal   = 1'b0;

        case (cur)
            ST_INIT: begin
                bus.pc_rst = 1'b1;
                nxt        = ST_FETCH;
            end
            ST_FETCH: begin
                bus.memRDEN1 = 1'b1;
                nxt          = ST_EXEC;
            end
            ST_EXEC: begin
                bus.imm_sel = imm_dec;
                case (bus.opcode)
                    OP_OP, OP_IMM, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: begin
                        bus.regWrite = 1'b1;
                        bus.PCWrite  = 1'b1;
                        done         = 1'b1;
                    end
                    OP_BRANCH: begin
                        bus.PCWrite = 1'b1;
                        done        = 1'b1;
                    end
                    OP_SYSTEM: begin
                        bus.PCWrite = 1'b1;
                        done        = 1'b1;
                        if (bus.func3 == F3_CSRRW) begin
                            bus.csr_WE   = 1'b1;
                            bus.regWrite = 1'b1;
                        end else if (bus.func3 == F3_MRET) begin
                            bus.mret_exec = 1'b1;
                        end
                    end
                    OP_LOAD: begin
                        bus.memRDEN2 = 1'b1;
                        nxt          = ST_MEM;
                    end
                    OP_STORE: begin
                        bus.memWE2 = 1'b1;
                        nxt        = ST_MEM;
                    end
                    default: begin
                        bus.illegal = 1'b1;
                        bus.PCWrite = 1'b1;
                        done        = 1'b1;
                    end
                endcase
            end
            ST_MEM: begin
                bus.imm_sel  = imm_dec;
                bus.memWE2   = store_flg;
                bus.memRDEN2 = ~store_flg;
                if (bus.mem_ack) begin
                    if (store_flg) begin
                        bus.PCWrite = 1'b1;
                        done        = 1'b1;
                    end else begin
                        nxt = ST_WB;
                    end
                end else if (wait_cnt == TIMEOUT_LAST) begin
                    bus.mem_fault = 1'b1;
                    bus.PCWrite   = 1'b1;
                    done          = 1'b1;
                end
            end
            ST_WB: begin
                bus.imm_sel  = imm_dec;
                bus.regWrite = 1'b1;
                bus.PCWrite  = 1'b1;
                done         = 1'b1;
            end
            ST_INTR: begin
                bus.int_taken = 1'b1;
                bus.PCWrite   = 1'b1;
                nxt           = ST_FETCH;
            end
            default: nxt = ST_INIT;
        endcase

        if (done) begin
            nxt = (bus.INTR && bus.MIE) ? ST_INTR : ST_FETCH;
        end

        bus.state = cur;
    end

    // State, MEM wait counter and load/store flag; counter restarts on every MEM entry.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cur       <= ST_INIT;
            wait_cnt  <= 8'd0;
            store_flg <= 1'b0;
        end else begin
            cur <= nxt;
            if (cur == ST_EXEC && nxt == ST_MEM) begin
                wait_cnt  <= 8'd0;
                store_flg <= (bus.opcode == OP_STORE);
            end else if (cur == ST_MEM && !bus.mem_ack) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_otter_cu_fsm.sv
// Directed bench for otter_cu_fsm (MEM_TIMEOUT=4); every cycle's outputs are
// compared against hand-computed vectors {state, imm_sel, flags}.
module tb_otter_cu_fsm;
    logic clk;
    logic rst;

    otter_cu_fsm_if bus ();

    otter_cu_fsm #(.MEM_TIMEOUT(4)) u_dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus.master)
    );

    localparam logic [2:0] S_INIT = 3'd0, S_FETCH = 3'd1, S_EXEC = 3'd2,
                           S_MEM  = 3'd3, S_WB    = 3'd4, S_INTR  = 3'd5;

    localparam logic [10:0] F_NONE  = 11'h000;
    localparam logic [10:0] F_PCRST = 11'h400;
    localparam logic [10:0] F_PCW   = 11'h200;
    localparam logic [10:0] F_RW    = 11'h100;
    localparam logic [10:0] F_RD1   = 11'h080;
    localparam logic [10:0] F_RD2   = 11'h040;
    localparam logic [10:0] F_WE2   = 11'h020;
    localparam logic [10:0] F_CSR   = 11'h010;
    localparam logic [10:0] F_IT    = 11'h008;
    localparam logic [10:0] F_MRET  = 11'h004;
    localparam logic [10:0] F_MF    = 11'h002;
    localparam logic [10:0] F_ILL   = 11'h001;

    localparam logic [6:0] OPC_ADDI   = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_BAD    = 7'b1111111;

    int unsigned n_cmp;
    int unsigned n_bad;

    logic [16:0] act;
    assign act = {bus.state, bus.imm_sel,
                  bus.pc_rst, bus.PCWrite, bus.regWrite, bus.memRDEN1, bus.memRDEN2,
                  bus.memWE2, bus.csr_WE, bus.int_taken, bus.mret_exec,
                  bus.mem_fault, bus.illegal};

    function automatic logic [16:0] ex(input logic [2:0] st, input logic [2:0] imm,
                                       input logic [10:0] fl);
        return {st, imm, fl};
    endfunction

    task automatic chk(input string tag, input logic [16:0] e);
        n_cmp++;
        assert (act === e) else begin
            n_bad++;
            $error("FAIL %s: observed st=%0d imm=%0d flags=%03h, expected st=%0d imm=%0d flags=%03h",
                   tag, act[16:14], act[13:11], act[10:0], e[16:14], e[13:11], e[10:0]);
        end
    endtask

    // Check one cycle mid-period, then return just after the next rising edge.
    task automatic cyc(input string tag, input logic [16:0] e);
        @(negedge clk);
        chk(tag, e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        n_cmp       = 0;
        n_bad       = 0;
        rst         = 1'b1;
        bus.INTR    = 1'b0;
        bus.MIE     = 1'b0;
        bus.opcode  = 7'd0;
        bus.func3   = 3'd0;
        bus.mem_ack = 1'b0;

        // Reset held three cycles, then one INIT cycle
        cyc("rst0", ex(S_INIT, 3'd0, F_PCRST));
        cyc("rst1", ex(S_INIT, 3'd0, F_PCRST));
        cyc("rst2", ex(S_INIT, 3'd0, F_PCRST));
        rst = 1'b0;
        cyc("init", ex(S_INIT, 3'd0, F_PCRST));

        // ADDI then JAL
        bus.opcode = OPC_ADDI;
        cyc("addi_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("addi_exec",  ex(S_EXEC,  3'd0, F_PCW | F_RW));
        bus.opcode = OPC_JAL;
        cyc("jal_fetch",  ex(S_FETCH, 3'd0, F_RD1));
        cyc("jal_exec",   ex(S_EXEC,  3'd4, F_PCW | F_RW));

        // LW, ack in third MEM cycle
        bus.opcode = OPC_LOAD;
        bus.func3  = 3'b010;
        cyc("lw_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("lw_exec",  ex(S_EXEC,  3'd0, F_RD2));
        cyc("lw_mem1",  ex(S_MEM,   3'd0, F_RD2));
        cyc("lw_mem2",  ex(S_MEM,   3'd0, F_RD2));
        bus.mem_ack = 1'b1;
        cyc("lw_mem3",  ex(S_MEM,   3'd0, F_RD2));
        bus.mem_ack = 1'b0;
        cyc("lw_wb",    ex(S_WB,    3'd0, F_PCW | F_RW));

        // SW with no ack: times out in MEM cycle 4
        bus.opcode = OPC_STORE;
        cyc("swt_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("swt_exec",  ex(S_EXEC,  3'd1, F_WE2));
        cyc("swt_mem1",  ex(S_MEM,   3'd1, F_WE2));
        cyc("swt_mem2",  ex(S_MEM,   3'd1, F_WE2));
        cyc("swt_mem3",  ex(S_MEM,   3'd1, F_WE2));
        cyc("swt_mem4",  ex(S_MEM,   3'd1, F_WE2 | F_PCW | F_MF));

        // SW with ack arriving in the timeout cycle: ack wins
        cyc("swa_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("swa_exec",  ex(S_EXEC,  3'd1, F_WE2));
        cyc("swa_mem1",  ex(S_MEM,   3'd1, F_WE2));
        cyc("swa_mem2",  ex(S_MEM,   3'd1, F_WE2));
        cyc("swa_mem3",  ex(S_MEM,   3'd1, F_WE2));
        bus.mem_ack = 1'b1;
        cyc("swa_mem4",  ex(S_MEM,   3'd1, F_WE2 | F_PCW));
        bus.mem_ack = 1'b0;

        // BEQ with interrupt enabled, then masked
        bus.opcode = OPC_BRANCH;
        bus.func3  = 3'b000;
        cyc("beq_fetch", ex(S_FETCH, 3'd0, F_RD1));
        bus.INTR = 1'b1;
        bus.MIE  = 1'b1;
        cyc("beq_exec",  ex(S_EXEC,  3'd2, F_PCW));
        cyc("beq_intr",  ex(S_INTR,  3'd0, F_IT | F_PCW));
        bus.MIE = 1'b0;
        cyc("beqm_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("beqm_exec",  ex(S_EXEC,  3'd2, F_PCW));
        bus.INTR = 1'b0;

        // SYSTEM variants and an illegal opcode
        bus.opcode = OPC_SYSTEM;
        bus.func3  = 3'b001;
        cyc("csrrw_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("csrrw_exec",  ex(S_EXEC,  3'd0, F_CSR | F_RW | F_PCW));
        bus.func3 = 3'b000;
        cyc("mret_fetch",  ex(S_FETCH, 3'd0, F_RD1));
        cyc("mret_exec",   ex(S_EXEC,  3'd0, F_MRET | F_PCW));
        bus.func3 = 3'b010;
        cyc("csrrs_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("csrrs_exec",  ex(S_EXEC,  3'd0, F_PCW));
        bus.opcode = OPC_BAD;
        cyc("bad_fetch",   ex(S_FETCH, 3'd0, F_RD1));
        cyc("bad_exec",    ex(S_EXEC,  3'd0, F_ILL | F_PCW));

        // Load with ack and interrupt held from FETCH: ack ignored until MEM, w=1,
        // interrupt deferred until after WB
        bus.opcode  = OPC_LOAD;
        bus.func3   = 3'b010;
        bus.mem_ack = 1'b1;
        bus.INTR    = 1'b1;
        bus.MIE     = 1'b1;
        cyc("lwi_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("lwi_exec",  ex(S_EXEC,  3'd0, F_RD2));
        cyc("lwi_mem1",  ex(S_MEM,   3'd0, F_RD2));
        cyc("lwi_wb",    ex(S_WB,    3'd0, F_PCW | F_RW));
        cyc("lwi_intr",  ex(S_INTR,  3'd0, F_IT | F_PCW));
        bus.mem_ack = 1'b0;
        bus.INTR    = 1'b0;
        bus.MIE     = 1'b0;

        // Reset mid-MEM of a load
        cyc("rl_fetch", ex(S_FETCH, 3'd0, F_RD1));
        cyc("rl_exec",  ex(S_EXEC,  3'd0, F_RD2));
        cyc("rl_mem1",  ex(S_MEM,   3'd0, F_RD2));
        #1;
        chk("rl_mem2", ex(S_MEM, 3'd0, F_RD2));
        #1;
        rst = 1'b1;
        #1;
        chk("rl_async", ex(S_INIT, 3'd0, F_PCRST));
        cyc("rl_hold",  ex(S_INIT, 3'd0, F_PCRST));
        rst = 1'b0;
        cyc("rl_init",  ex(S_INIT, 3'd0, F_PCRST));
        cyc("rl_after", ex(S_FETCH, 3'd0, F_RD1));
        chk("rl_exec2", ex(S_EXEC, 3'd0, F_RD2) | {6'd0, F_NONE});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
